multi_digit_updown_counter_disp: RTL

- Parametrised successor to the single-digit display counter: a true multi-digit BCD counter driving NUM_DIGITS active-low 7-segment displays (8 bits each, segment order a..g then dp).
- Adds a tick prescaler, up/down mode, enable, synchronous load, terminal-count detect and leading-zero blanking.
- Sits between the board clock and the on-board 7-segment banks.

---
 rtl/multi_digit_updown_counter_disp.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/multi_digit_updown_counter_disp.sv
// Multi-digit BCD up/down counter with tick prescaler, synchronous load, terminal-count
// detect and registered active-low 7-segment outputs with optional leading-zero blanking.
module multi_digit_updown_counter_disp #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned CLK_DIV    = 25000000,
    parameter int unsigned DIV_W      = 25,
    parameter int unsigned BLANK_LZ   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic                    tick,
    output logic                    tc,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic [8*NUM_DIGITS-1:0] seg
);

    localparam int unsigned CntW = 4 * NUM_DIGITS;
    localparam int unsigned SegW = 8 * NUM_DIGITS;

    localparam logic [DIV_W-1:0] DivLast = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DivOne  = DIV_W'(1);

    localparam logic [7:0] SegZero  = 8'b00000011;
    localparam logic [7:0] SegBlank = 8'hFF;

    // Bit 7 is segment a, bit 0 is dp; non-BCD nibbles light nothing.
    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return 8'b00000011;
            4'd1:    return 8'b10011111;
            4'd2:    return 8'b00100101;
            4'd3:    return 8'b00001101;
            4'd4:    return 8'b10011001;
            4'd5:    return 8'b01001001;
            4'd6:    return 8'b01000001;
            4'd7:    return 8'b00011111;
            4'd8:    return 8'b00000001;
            4'd9:    return 8'b00001001;
            default: return SegBlank;
        endcase
    endfunction

    function automatic logic [SegW-1:0] reset_pattern();
        logic [SegW-1:0] p;
        p = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            p[8*i +: 8] = (BLANK_LZ != 0 && i != 0) ? SegBlank : SegZero;
        end
        return p;
    endfunction

    localparam logic [SegW-1:0] SegReset = reset_pattern();

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [CntW-1:0]  count_q, count_d, count_step;
    logic [SegW-1:0]  seg_q, seg_d;

    assign tick  = en && (presc_q == DivLast);
    assign count = count_q;
    assign seg   = seg_q;

    always_comb begin
        presc_d = presc_q;
        if (load) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = tick ? '0 : presc_q + DivOne;
        end
    end

    // Ripple carry/borrow through the digits; out-of-range nibbles behave like 9 (up) / 0 (down).
    always_comb begin
        logic       carry;
        logic [3:0] digit;
        carry      = 1'b1;
        digit      = '0;
        count_step = count_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            digit = count_q[4*i +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (digit >= 4'd9) begin
                        count_step[4*i +: 4] = 4'd0;
                    end else begin
                        count_step[4*i +: 4] = digit + 4'd1;
                        carry                = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0 || digit > 4'd9) begin
                        count_step[4*i +: 4] = 4'd9;
                    end else begin
                        count_step[4*i +: 4] = digit - 4'd1;
                        carry                = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick) begin
            count_d = count_step;
        end
    end

    always_comb begin
        logic all_nine;
        logic all_zero;
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            all_nine = all_nine & (count_q[4*i +: 4] == 4'd9);
            all_zero = all_zero & (count_q[4*i +: 4] == 4'd0);
        end
        tc = up_dn ? all_nine : all_zero;
    end

    // Walk from the most significant digit so each digit knows whether anything above is nonzero.
    always_comb begin
        logic       nz_seen;
        logic [3:0] digit;
        nz_seen = 1'b0;
        digit   = '0;
        seg_d   = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            digit   = count_q[4*i +: 4];
            nz_seen = nz_seen | (digit != 4'd0);
            if (BLANK_LZ != 0 && i != 0 && !nz_seen) begin
                seg_d[8*i +: 8] = SegBlank;
            end else begin
                seg_d[8*i +: 8] = seg_encode(digit);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            count_q <= '0;
            seg_q   <= SegReset;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            seg_q   <= seg_d;
        end
    end

endmodule
